// File: rtl/fb_vport_pkg.sv
// Shared types and helpers for the framebuffer video port: FSM states, FIFO entry
// layout, raster total derivation, RGB555 expansion and the colour-bar table.
package fb_vport_pkg;

   typedef enum logic {
      SYNC = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic        start;
      logic [14:0] pixel;
   } st_word_t;

   function automatic int timing_total(input int active, input int fp, input int sync,
                                       input int bp);
      return active + fp + sync + bp;
   endfunction

   // Bit replication keeps full-scale 5-bit values at full-scale 8-bit.
   function automatic logic [7:0] expand5(input logic [4:0] c);
      return {c, c[4:2]};
   endfunction

   function automatic logic [23:0] rgb555_to_888(input logic [14:0] p);
      return {expand5(p[14:10]), expand5(p[9:5]), expand5(p[4:0])};
   endfunction

   // {R,G,B} on/off per bar, left to right.
   localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                          3'b101, 3'b100, 3'b001, 3'b000};

   function automatic logic [23:0] bar_colour(input logic [2:0] idx);
      logic [2:0] c;
      c = BAR_RGB[idx];
      return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
   endfunction

endpackage

// File: rtl/fb_vport_if.sv
// Framebuffer pixel stream: master is the pixel source, slave is the video port sink.
interface fb_vport_if;
   logic [14:0] st_data;
   logic        st_start;
   logic        st_dv;
   logic        st_ready;

   modport master (output st_data, output st_start, output st_dv, input st_ready);
   modport slave  (input st_data, input st_start, input st_dv, output st_ready);
endinterface

// File: rtl/fb_vport_fifo.sv
// Synchronous show-ahead FIFO: head entry is visible before it is popped.
// Push when full and pop when empty are ignored.
module fb_vport_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_head,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_full;
   logic             w_push_ok;
   logic             w_pop_ok;

   assign w_full    = (r_count == FULL_C);
   assign o_empty   = (r_count == '0);
   assign w_push_ok = i_push & ~w_full;
   assign w_pop_ok  = i_pop & ~o_empty;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_count   = r_count;

   always_ff @(posedge i_clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= r_count + (AW+1)'(w_push_ok) - (AW+1)'(w_pop_ok);
      end
   end
endmodule

// File: rtl/fb_vport_gen.sv
// Video timing generator and pixel-stream sink; locks the stream to the raster on START.
// Define FB_VPORT_TEST_PATTERN_EN to add iPATTERN and the colour-bar generator.
module fb_vport_gen
   import fb_vport_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_ACTIVE   = 480,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b0,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       iCLK,
   input  logic       iRESET,
`ifdef FB_VPORT_TEST_PATTERN_EN
   input  logic       iPATTERN,
`endif
   fb_vport_if.slave  st,
   output logic [7:0] oRED,
   output logic [7:0] oGRN,
   output logic [7:0] oBLU,
   output logic       oHS,
   output logic       oVS,
   output logic       oDE,
   output logic       oLOCKED,
   output logic       oUNDERFLOW
);
   localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] HS_BEG_C = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] HS_END_C = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] VS_BEG_C = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] VS_END_C = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
   localparam logic [CW-1:0] FIFO_C   = CW'(FIFO_DEPTH);

   logic [HW-1:0] r_hcnt;
   logic [VW-1:0] r_vcnt;
   state_t        r_state;
   logic [7:0]    r_red, r_grn, r_blu;
   logic          r_hs, r_vs, r_de, r_locked, r_underflow;

   st_word_t      w_head;
   logic [CW-1:0] w_count;
   logic          w_empty, w_push, w_pop, w_drop, w_show;
   logic          w_h_last, w_v_last, w_frame_end, w_origin, w_active;
   logic          w_hs_on, w_vs_on, w_head_start;
   logic          w_pat_req, w_pat_on;
   logic [23:0]   w_bar;
   logic [23:0]   w_rgb;

   assign st.st_ready = ~iRESET & (w_count < FIFO_C);
   assign w_push      = st.st_dv & st.st_ready;

   fb_vport_fifo #(
      .WIDTH (16),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (iCLK),
      .i_rst   (iRESET),
      .i_push  (w_push),
      .i_data  ({st.st_start, st.st_data}),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_count (w_count),
      .o_empty (w_empty)
   );

   assign w_h_last     = (r_hcnt == H_LAST_C);
   assign w_v_last     = (r_vcnt == V_LAST_C);
   assign w_frame_end  = w_h_last & w_v_last;
   assign w_origin     = (r_hcnt == '0) && (r_vcnt == '0);
   assign w_active     = (r_hcnt < H_ACT_C) && (r_vcnt < V_ACT_C);
   assign w_hs_on      = (r_hcnt >= HS_BEG_C) && (r_hcnt < HS_END_C);
   assign w_vs_on      = (r_vcnt >= VS_BEG_C) && (r_vcnt < VS_END_C);
   assign w_head_start = ~w_empty & w_head.start;

`ifdef FB_VPORT_TEST_PATTERN_EN
   localparam int BAR_W = H_ACTIVE / 8;
   logic r_pattern;

   // Pattern selection only changes at the frame boundary.
   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET)           r_pattern <= 1'b0;
      else if (w_frame_end) r_pattern <= iPATTERN;
   end

   assign w_pat_req = iPATTERN;
   assign w_pat_on  = r_pattern;
   assign w_bar     = bar_colour(3'(32'(r_hcnt) / BAR_W));
`else
   assign w_pat_req = 1'b0;
   assign w_pat_on  = 1'b0;
   assign w_bar     = 24'h0;
`endif

   // SYNC drains stale pixels but keeps a start-flagged head for the next frame.
   always_comb begin
      w_pop  = 1'b0;
      w_drop = 1'b0;
      w_show = 1'b0;
      case (r_state)
         SYNC: w_pop = ~w_empty & ~w_head.start;
         RUN: begin
            if (w_active) begin
               if (w_empty || (w_head.start && !w_origin)) begin
                  w_drop = 1'b1;
               end else begin
                  w_pop  = 1'b1;
                  w_show = 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      w_rgb = 24'h0;
      if (w_show)                   w_rgb = rgb555_to_888(w_head.pixel);
      else if (w_pat_on && w_active) w_rgb = w_bar;
   end

   always_ff @(posedge iCLK or posedge iRESET) begin
      if (iRESET) begin
         r_hcnt      <= '0;
         r_vcnt      <= '0;
         r_state     <= SYNC;
         r_red       <= 8'h0;
         r_grn       <= 8'h0;
         r_blu       <= 8'h0;
         r_de        <= 1'b0;
         r_hs        <= ~HS_POL;
         r_vs        <= ~VS_POL;
         r_locked    <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_h_last) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
         end else begin
            r_hcnt <= r_hcnt + 1'b1;
         end
         r_de                  <= w_active;
         r_hs                  <= w_hs_on ? HS_POL : ~HS_POL;
         r_vs                  <= w_vs_on ? VS_POL : ~VS_POL;
         {r_red, r_grn, r_blu} <= w_rgb;
         r_underflow           <= w_drop;
         case (r_state)
            SYNC: begin
               if (w_frame_end && w_head_start && !w_pat_req) begin
                  r_state  <= RUN;
                  r_locked <= 1'b1;
               end
            end
            RUN: begin
               if (w_drop || (w_frame_end && (!w_head_start || w_pat_req))) begin
                  r_state  <= SYNC;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               r_state  <= SYNC;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

   assign oRED       = r_red;
   assign oGRN       = r_grn;
   assign oBLU       = r_blu;
   assign oHS        = r_hs;
   assign oVS        = r_vs;
   assign oDE        = r_de;
   assign oLOCKED    = r_locked;
   assign oUNDERFLOW = r_underflow;
endmodule
